acc_cpu_core: RTL and testbench
===============================

Name: acc_cpu_core

Overview:
- Parametrised multi-cycle accumulator CPU core; successor to the fixed 4-bit-address / 8-bit-word core.
- Full fetch / decode / indirect / execute / store sequence, carry flag, jump and halt.
- Talks to an external single-port memory through a req/ready handshake, so wait-state memories are supported.
- Sits between the memory model and the test harness; exposes PC/AC/E/halted for observation.

Parameters:
- DATA_W, 8: word and accumulator width; must satisfy DATA_W >= ADDR_W+4.
- ADDR_W, 4: address width; PC, AR and mem_addr all use this width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  ADDR_W  access address.
- mem_wdata  output  DATA_W  store data (AC).
- mem_rdata  input  DATA_W  read data; valid in the cycle mem_ready=1.
- mem_ready  input  1  access completes on a rising edge where mem_req=1 and mem_ready=1.
- pc  output  ADDR_W  program counter.
- ac  output  DATA_W  accumulator.
- e_flag  output  1  carry/not-borrow flag.
- halted  output  1  core is in HALT state.

Behaviour:
- Reset (async, RST_N=0):
  - State = FETCH; PC = RESET_PC; AC, IR, AR, DR, E = 0.
  - mem_req = 0 and halted = 0, immediately (combinationally forced).
  - Reset mid-access abandons the transaction with no side effects.
- Instruction format:
  - IR[DATA_W-1] = I (indirect bit).
  - IR[DATA_W-2:DATA_W-4] = opcode.
  - IR[ADDR_W-1:0] = address; remaining bits are ignored.
- Handshake:
  - mem_req/mem_we/mem_addr/mem_wdata are decoded from state and held stable until the completing edge.
  - The state advances only on completion; any number of wait cycles is allowed.
  - mem_ready while mem_req=0 is ignored.
- FETCH:
  - Read at PC.
  - On completion: IR <= rdata, PC <= PC+1 (wraps mod 2^ADDR_W), go to DECODE.
- DECODE (1 cycle, no memory access). Loads AR <= IR address field, then:
  - opcode 110 (CMA): AC <= ~AC; go to FETCH.
  - opcode 111, I=0 (JMP): PC <= address field; go to FETCH.
  - opcode 111, I=1 (HLT): go to HALT.
  - Opcodes 000-101: go to INDIRECT if I=1, else to STORE (opcode 101) or OPERAND (all others).
- INDIRECT:
  - Read at AR.
  - On completion: AR <= rdata[ADDR_W-1:0]; go to STORE (101) or OPERAND.
- OPERAND:
  - Read at AR.
  - On completion: DR <= rdata; go to EXEC.
- EXEC (1 cycle), then go to FETCH. Arithmetic is DATA_W wide, modulo 2^DATA_W:
  - 000 ADD: {E,AC} <= AC+DR.
  - 001 SUB: AC <= AC-DR; E <= (AC >= DR), unsigned.
  - 010 XOR: AC <= AC^DR; E unchanged.
  - 011 SHL: {E,AC} <= AC+AC; DR is fetched but unused.
  - 100 LDA: AC <= DR; E unchanged.
- STORE:
  - Write AC at AR.
  - On completion go to FETCH; AC and E unchanged.
- HALT:
  - halted=1, mem_req=0, all registers frozen.
  - Exit only via reset.
- Latency with mem_ready tied 1:
  - CMA/JMP: 2 cycles.
  - STA: 3 cycles.
  - ADD/SUB/XOR/SHL/LDA: 4 cycles.
  - Indirect addressing: +1 cycle.
  - HLT: halted rises 2 cycles after the fetch request.
  - Each wait cycle adds 1.
- PC wrap: fetch at address 2^ADDR_W-1 sets PC to 0; no flag is raised.

Test Plan:
- Defaults, ready=1. M[0]=0x49 (LDA 9), M[1]=0x0A (ADD 10), M[2]=0x5B (STA 11), M[3]=0xF0 (HLT); M[9]=0xF0, M[10]=0x25.
  -> AC=0x15, E=1, M[11]=0x15; halted=1 exactly 13 cycles after reset release; pc=4.
- Indirect: M[0]=0xC5 (LDA I 5), M[5]=0x07, M[7]=0x3C.
  -> AC=0x3C after 5 cycles; second read address is 7.
- Wait states: mem_ready high only every third cycle.
  -> Same final state as scenario 1.
  -> mem_addr/mem_we held stable across every wait cycle.
  -> No register changes before completion.
- SUB/CMA/JMP: AC=0x05, SUB of DR=0x06 -> AC=0xFF, E=0. Then CMA -> AC=0x00. Then JMP 0xE -> next fetch address 14.
- PC wrap: RESET_PC=15, M[15]=0x60 (CMA).
  -> After the fetch completes pc=0; next fetch address is 0.
- Async reset asserted during a wait-stated STORE.
  -> mem_req drops in the same cycle; no write occurs.
  -> pc=RESET_PC, ac=0, halted=0.
  -> Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core with a req/ready memory port.
// Each instruction walks FETCH -> DECODE -> [INDIRECT] -> OPERAND/STORE -> EXEC.
// The memory port tolerates any number of wait cycles. HLT parks the core
// until reset.
module acc_cpu_core #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              e_flag,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_INDIRECT = 3'd2,
    S_OPERAND  = 3'd3,
    S_EXEC     = 3'd4,
    S_STORE    = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMA = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   ir;
  logic [ADDR_W-1:0]   ar;
  logic [DATA_W-1:0]   dr;
  logic                req_raw;
  logic                we_raw;
  logic                done;
  logic                ind;
  logic [2:0]          opcode;
  logic [ADDR_W-1:0]   addr_f;

  // Instruction fields: I bit on top, opcode below it, address in the low bits.
  assign ind    = ir[DATA_W-1];
  assign opcode = ir[DATA_W-2:DATA_W-4];
  assign addr_f = ir[ADDR_W-1:0];

  // A transfer completes only on an edge where we request and memory is ready.
  assign done = req_raw & mem_ready;

  // Reset forces the request and the halt indication low without waiting for a clock.
  assign mem_req   = req_raw & RST_N;
  assign mem_we    = we_raw & RST_N;
  assign halted    = (state == S_HALT) & RST_N;
  assign mem_wdata = ac;

  // EXEC result as {E, AC}; operations that leave E alone pass the old flag through.
  function automatic logic [DATA_W:0] alu(input logic [2:0]        op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] d,
                                          input logic              e);
    logic [DATA_W:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, d};
      OP_SUB:  r = {(a >= d), a - d};
      OP_XOR:  r = {e, a ^ d};
      OP_SHL:  r = {a, 1'b0};
      OP_LDA:  r = {e, d};
      default: r = {e, a};
    endcase
    return r;
  endfunction

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state decode and memory-port drive; port signals depend only on state.
  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    we_raw    = 1'b0;
    mem_addr  = ar;
    case (state)
      S_FETCH: begin
        req_raw  = 1'b1;
        mem_addr = pc;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_CMA)      state_nxt = S_FETCH;
        else if (opcode == OP_JMP) state_nxt = ind ? S_HALT : S_FETCH;
        else if (ind)              state_nxt = S_INDIRECT;
        else if (opcode == OP_STA) state_nxt = S_STORE;
        else                       state_nxt = S_OPERAND;
      end
      S_INDIRECT: begin
        req_raw = 1'b1;
        if (mem_ready) state_nxt = (opcode == OP_STA) ? S_STORE : S_OPERAND;
      end
      S_OPERAND: begin
        req_raw = 1'b1;
        if (mem_ready) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
      end
      S_STORE: begin
        req_raw = 1'b1;
        we_raw  = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_HALT;
      end
    endcase
  end

  // Architectural registers; memory-fed ones update only on a completing edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc     <= RESET_PC;
      ac     <= '0;
      e_flag <= 1'b0;
      ir     <= '0;
      ar     <= '0;
      dr     <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (done) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        S_DECODE: begin
          ar <= addr_f;
          if (opcode == OP_CMA)                ac <= ~ac;
          else if (opcode == OP_JMP && !ind)   pc <= addr_f;
        end
        S_INDIRECT: begin
          if (done) ar <= mem_rdata[ADDR_W-1:0];
        end
        S_OPERAND: begin
          if (done) dr <= mem_rdata;
        end
        S_EXEC: begin
          {e_flag, ac} <= alu(opcode, ac, dr, e_flag);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed programs, a per-instruction vector table,
// a reset-during-store sequence and random programs against an ISA-level model.
module tb_acc_cpu_core;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       mem_req, mem_we, mem_ready = 1'b1;
  logic [3:0] mem_addr, pc;
  logic [7:0] mem_wdata, mem_rdata, ac;
  logic       e_flag, halted;

  logic       w_req, w_we, w_e, w_halted;
  logic       w_ready;
  logic [3:0] w_addr, w_pc;
  logic [7:0] w_wdata, w_rdata, w_ac;

  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       load = 1'b0;
  logic [3:0] log_addr [64];
  logic       log_we [64];
  int         log_n = 0;
  int         mode = 0;
  int         rcnt = 0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] ac0;
    logic [7:0] dr;
    logic [7:0] ac;
    logic       e;
    logic [3:0] pc;
    int         cyc;
    logic [7:0] m15;
  } vec_t;
  vec_t vecs [12];

  int ref_mem [16];
  int m_ac, m_e, m_pc;

  acc_cpu_core dut (
    .CLK(CLK), .RST_N(RST_N), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .ac(ac), .e_flag(e_flag), .halted(halted)
  );

  acc_cpu_core #(.DATA_W(8), .ADDR_W(4), .RESET_PC(4'd15)) u_wrap (
    .CLK(CLK), .RST_N(RST_N), .mem_req(w_req), .mem_we(w_we),
    .mem_addr(w_addr), .mem_wdata(w_wdata), .mem_rdata(w_rdata),
    .mem_ready(w_ready), .pc(w_pc), .ac(w_ac), .e_flag(w_e), .halted(w_halted)
  );

  always #5 CLK = ~CLK;

  assign w_ready   = 1'b1;
  assign w_rdata   = (w_addr == 4'hF) ? 8'h60 : ((w_addr == 4'h0) ? 8'hF0 : 8'h00);
  assign mem_rdata = mem[mem_addr];

  // Memory model: image load, completed-access log, writes.
  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
      log_n <= 0;
    end else if (mem_req && mem_ready) begin
      log_addr[log_n[5:0]] <= mem_addr;
      log_we[log_n[5:0]]   <= mem_we;
      log_n <= log_n + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  // Ready pattern: 0 tied high, 1 every third cycle, 2 held low, 3 random.
  always @(negedge CLK) begin
    rcnt = rcnt + 1;
    case (mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (rcnt % 3 == 2);
      2:       mem_ready = 1'b0;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; across a wait edge the port and registers must not move.
  task automatic step();
    logic       p_req, p_we, p_rdy, p_rst, p_e;
    logic [3:0] p_addr, p_pc;
    logic [7:0] p_ac;
    @(negedge CLK); #1;
    p_req = mem_req; p_we = mem_we; p_rdy = mem_ready; p_rst = RST_N;
    p_addr = mem_addr; p_pc = pc; p_ac = ac; p_e = e_flag;
    @(posedge CLK); #1;
    cyc++;
    if (p_rst && RST_N && p_req && !p_rdy) begin
      check("wait_hold_port", {mem_req, mem_we, mem_addr}, {1'b1, p_we, p_addr});
      check("wait_hold_regs", {pc, ac, e_flag}, {p_pc, p_ac, p_e});
    end
  endtask

  task automatic do_reset(input bit chk);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    load = 1'b1;
    @(posedge CLK); #1;
    load = 1'b0;
    if (chk) begin
      check("rst_req", mem_req, 0);
      check("rst_halted", halted, 0);
      check("rst_pc", pc, 0);
      check("rst_ac_e", {ac, e_flag}, 0);
      check("rst_wrap_pc", w_pc, 15);
    end
    @(posedge CLK); #2;
    RST_N = 1'b1;
    cyc = 0;
  endtask

  task automatic run_to_halt(input int bound);
    while (!halted && cyc < bound) step();
    check("halt_reached", halted, 1);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  // Instruction-level interpreter over ref_mem.
  task automatic run_model();
    int p, a, ee, w, ind, op, ad, d;
    p = 0; a = 0; ee = 0;
    for (int n = 0; n < 64; n++) begin
      w = ref_mem[p]; ind = (w >> 7) & 1; op = (w >> 4) & 7; ad = w & 15;
      p = (p + 1) % 16;
      if (op == 7) begin
        if (ind == 1) break;
        p = ad;
      end else if (op == 6) begin
        a = (~a) & 255;
      end else begin
        if (ind == 1) ad = ref_mem[ad] & 15;
        if (op == 5) ref_mem[ad] = a;
        else begin
          d = ref_mem[ad];
          case (op)
            0: begin ee = (a + d > 255) ? 1 : 0; a = (a + d) % 256; end
            1: begin ee = (a >= d) ? 1 : 0; a = (a - d + 256) % 256; end
            2: a = a ^ d;
            3: begin ee = (a >= 128) ? 1 : 0; a = (a * 2) % 256; end
            default: a = d;
          endcase
        end
      end
    end
    m_ac = a; m_e = ee; m_pc = p;
  endtask

  initial begin
    int n0, w, op;
    vecs[0]  = '{8'h0F, 8'hF0, 8'h25, 8'h15, 1'b1, 4'd3, 10, 8'h25};
    vecs[1]  = '{8'h0F, 8'h10, 8'h20, 8'h30, 1'b0, 4'd3, 10, 8'h20};
    vecs[2]  = '{8'h1F, 8'h05, 8'h06, 8'hFF, 1'b0, 4'd3, 10, 8'h06};
    vecs[3]  = '{8'h1F, 8'h40, 8'h10, 8'h30, 1'b1, 4'd3, 10, 8'h10};
    vecs[4]  = '{8'h1F, 8'h33, 8'h33, 8'h00, 1'b1, 4'd3, 10, 8'h33};
    vecs[5]  = '{8'h2F, 8'hA5, 8'hFF, 8'h5A, 1'b0, 4'd3, 10, 8'hFF};
    vecs[6]  = '{8'h3F, 8'h81, 8'h55, 8'h02, 1'b1, 4'd3, 10, 8'h55};
    vecs[7]  = '{8'h4F, 8'h12, 8'h7E, 8'h7E, 1'b0, 4'd3, 10, 8'h7E};
    vecs[8]  = '{8'h5F, 8'h99, 8'h44, 8'h99, 1'b0, 4'd3, 9,  8'h99};
    vecs[9]  = '{8'h60, 8'h5A, 8'h00, 8'hA5, 1'b0, 4'd3, 8,  8'h00};
    vecs[10] = '{8'h73, 8'h11, 8'h00, 8'h11, 1'b0, 4'd4, 8,  8'h00};
    vecs[11] = '{8'h8D, 8'h01, 8'hFF, 8'h00, 1'b1, 4'd3, 11, 8'hFF};

    // Basic program with ready tied high; the wrap core runs alongside.
    mode = 0;
    clear_img();
    img[0] = 8'h49; img[1] = 8'h0A; img[2] = 8'h5B; img[3] = 8'hF0;
    img[9] = 8'hF0; img[10] = 8'h25;
    do_reset(1'b1);
    step();
    check("wrap_pc", w_pc, 0);
    step();
    check("wrap_cma_ac", w_ac, 8'hFF);
    check("wrap_next_fetch", {w_req, w_addr}, {1'b1, 4'h0});
    run_to_halt(100);
    check("basic_cycles", cyc, 13);
    check("basic_ac", ac, 8'h15);
    check("basic_e", e_flag, 1);
    check("basic_m11", mem[11], 8'h15);
    check("basic_pc", pc, 4);

    // Indirect load.
    clear_img();
    img[0] = 8'hC5; img[1] = 8'hF0; img[5] = 8'h07; img[7] = 8'h3C;
    do_reset(1'b0);
    repeat (5) step();
    check("ind_ac", ac, 8'h3C);
    check("ind_ptr_addr", log_addr[1], 5);
    check("ind_operand_addr", log_addr[2], 7);

    // Same basic program with wait states.
    mode = 1;
    clear_img();
    img[0] = 8'h49; img[1] = 8'h0A; img[2] = 8'h5B; img[3] = 8'hF0;
    img[9] = 8'hF0; img[10] = 8'h25;
    do_reset(1'b0);
    run_to_halt(300);
    check("ws_slower", (cyc > 13) ? 1 : 0, 1);
    check("ws_ac_e", {ac, e_flag}, {8'h15, 1'b1});
    check("ws_m11", mem[11], 8'h15);
    check("ws_pc", pc, 4);

    // SUB with borrow, CMA, JMP.
    mode = 0;
    clear_img();
    img[0] = 8'h4C; img[1] = 8'h1D; img[2] = 8'h60; img[3] = 8'h7E;
    img[12] = 8'h05; img[13] = 8'h06; img[14] = 8'hF0;
    do_reset(1'b0);
    repeat (8) step();
    check("sub_ac", ac, 8'hFF);
    check("sub_e", e_flag, 0);
    repeat (2) step();
    check("cma_ac", ac, 8'h00);
    repeat (2) step();
    check("jmp_pc", pc, 14);
    check("jmp_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 4'hE});
    run_to_halt(50);
    check("jmp_final_pc", pc, 15);

    // Per-instruction vectors: LDA 14 preamble, instruction, HLT.
    for (int i = 0; i < 12; i++) begin
      clear_img();
      img[0] = 8'h4E; img[1] = vecs[i].instr; img[2] = 8'hF0; img[3] = 8'hF0;
      img[13] = 8'h0F; img[14] = vecs[i].ac0; img[15] = vecs[i].dr;
      do_reset(1'b0);
      run_to_halt(100);
      check($sformatf("vec%0d_ac", i), ac, vecs[i].ac);
      check($sformatf("vec%0d_e", i), e_flag, vecs[i].e);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("vec%0d_m15", i), mem[15], vecs[i].m15);
    end

    // Reset asserted while a store is waiting.
    mode = 0;
    clear_img();
    img[0] = 8'h4C; img[1] = 8'h5B; img[11] = 8'h77; img[12] = 8'h33;
    do_reset(1'b0);
    repeat (5) step();
    mode = 2;
    repeat (2) step();
    check("st_wait_port", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 4'hB});
    check("st_wait_ac", ac, 8'h33);
    #1;
    RST_N = 1'b0;
    #1;
    check("st_rst_req", mem_req, 0);
    check("st_rst_state", {pc, ac, e_flag, halted}, 0);
    n0 = log_n;
    mode = 0;
    @(posedge CLK);
    @(posedge CLK); #1;
    check("st_rst_no_access", log_n, n0);
    check("st_rst_m11", mem[11], 8'h77);
    #1;
    RST_N = 1'b1;
    step();
    check("st_restart_count", log_n, n0 + 1);
    check("st_restart_addr", {log_we[n0[5:0]], log_addr[n0[5:0]]}, 0);

    // Random forward-flowing programs under random ready.
    mode = 3;
    for (int t = 0; t < 20; t++) begin
      clear_img();
      for (int i = 0; i < 10; i++) begin
        op = int'($urandom_range(0, 7));
        case (op)
          7:       w = 8'h70 | int'($urandom_range(i + 1, 10));
          6:       w = 8'h60;
          5:       w = 8'h50 | int'($urandom_range(11, 15));
          default: w = (int'($urandom_range(0, 1)) << 7) | (op << 4) | int'($urandom_range(11, 15));
        endcase
        img[i] = 8'(w);
      end
      img[10] = 8'hF0;
      for (int i = 11; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 16; i++) ref_mem[i] = int'(img[i]);
      run_model();
      do_reset(1'b0);
      run_to_halt(3000);
      check($sformatf("rnd%0d_ac", t), ac, m_ac);
      check($sformatf("rnd%0d_e", t), e_flag, m_e);
      check($sformatf("rnd%0d_pc", t), pc, m_pc);
      for (int i = 11; i < 16; i++)
        check($sformatf("rnd%0d_m%0d", t, i), mem[i], ref_mem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
